// File: rtl/icache_assoc_param_pkg.sv
// Shared types and width helpers for the
// set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    FILL   = 2'd3
  } state_e;

  function automatic int calc_set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_word_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int calc_tag_w(input int addr_w,
                                    input int sets,
                                    input int wpl);
    return addr_w - $clog2(sets) - $clog2(wpl);
  endfunction

  function automatic int calc_line_w(input int wpl,
                                     input int inst_w);
    return wpl * inst_w;
  endfunction

  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int TAG_W  = calc_tag_w(8, 4, 4);
  localparam int SET_W  = calc_set_w(4);
  localparam int WORD_W = calc_word_w(4);
  localparam int LINE_W = calc_line_w(4, 16);

endpackage

// File: rtl/icache_assoc_param_if.sv
// Fetch-side and memory-side bus of the cache.
// master = fetch unit + memory, slave = cache.
interface icache_assoc_param_if #(
  parameter int ADDR_W         = 8,
  parameter int INST_W         = 16,
  parameter int WORDS_PER_LINE = 4
);
  localparam int LA_W = ADDR_W - $clog2(WORDS_PER_LINE);
  localparam int LN_W = WORDS_PER_LINE * INST_W;

  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic              rd_rdy;
  logic [INST_W-1:0] inst;
  logic              flush;
  logic              mem_rd_en;
  logic [LA_W-1:0]   mem_addr;
  logic              mem_rd_rdy;
  logic [LN_W-1:0]   mem_data;

  modport master (
    output rd_en, addr, flush,
    output mem_rd_rdy, mem_data,
    input  rd_rdy, inst,
    input  mem_rd_en, mem_addr
  );

  modport slave (
    input  rd_en, addr, flush,
    input  mem_rd_rdy, mem_data,
    output rd_rdy, inst,
    output mem_rd_en, mem_addr
  );
endinterface

// File: rtl/icache_assoc_param_way_array.sv
// Per-way tag/valid/data storage with a
// parallel tag compare on the addressed set.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 4,
  parameter int TAG_W  = 4,
  parameter int LINE_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [calc_set_w(SETS)-1:0] set,
  input  logic [TAG_W-1:0]           rd_tag,
  input  logic                       wr_en,
  input  logic [calc_way_w(WAYS)-1:0] wr_way,
  input  logic [LINE_W-1:0]          wr_data,
  output logic [WAYS-1:0]            hit_vec,
  output logic [WAYS-1:0]            valid_vec,
  output logic [LINE_W-1:0]          hit_data
);
  localparam int WAY_W = calc_way_w(WAYS);

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];

  // valid bits: flush beats a same-cycle fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        valid_q[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < SETS; s++)
        valid_q[s] <= '0;
    end else if (wr_en) begin
      for (int w = 0; w < WAYS; w++)
        if (wr_way == WAY_W'(w))
          valid_q[set][w] <= 1'b1;
    end
  end

  // tag and line payload, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int w = 0; w < WAYS; w++)
        if (wr_way == WAY_W'(w)) begin
          tag_q[w][set]  <= rd_tag;
          data_q[w][set] <= wr_data;
        end
    end
  end

  // parallel compare; hit vector is one-hot
  always_comb begin
    hit_vec   = '0;
    hit_data  = '0;
    valid_vec = valid_q[set];
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[set][w] &&
                   (tag_q[w][set] == rd_tag);
      if (hit_vec[w])
        hit_data = hit_data | data_q[w][set];
    end
  end

endmodule

// File: rtl/icache_assoc_param.sv
// Parametrised set-associative read-only
// instruction cache with flush and counters.
module icache_assoc_param
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int INST_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 4,
  parameter int WAYS           = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  icache_assoc_param_if.slave bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int WORD_W = calc_word_w(WORDS_PER_LINE);
  localparam int SET_W  = calc_set_w(SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_W, SETS,
                                     WORDS_PER_LINE);
  localparam int LINE_W = calc_line_w(WORDS_PER_LINE,
                                      INST_W);
  localparam int LA_W   = ADDR_W - WORD_W;
  localparam int WAY_W  = calc_way_w(WAYS);

  state_e            state;
  logic [ADDR_W-1:0] req_addr;
  logic [INST_W-1:0] fill_inst;
  logic [WAY_W-1:0]  rr_q [SETS];
  logic [WAY_W-1:0]  victim;
  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   valid_vec;
  logic [LINE_W-1:0] hit_data;

  logic [LA_W-1:0]   line_addr;
  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WORD_W-1:0] word;
  logic              hit;
  logic              fill_en;

  assign line_addr = req_addr[ADDR_W-1:WORD_W];
  assign set_idx   = line_addr[SET_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign word      = req_addr[WORD_W-1:0];
  assign hit       = |hit_vec;
  assign fill_en   = (state == MISS) && bus.mem_rd_rdy;

  icache_way_array #(
    .WAYS   (WAYS),
    .SETS   (SETS),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_ways (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .set       (set_idx),
    .rd_tag    (req_tag),
    .wr_en     (fill_en),
    .wr_way    (victim),
    .wr_data   (bus.mem_data),
    .hit_vec   (hit_vec),
    .valid_vec (valid_vec),
    .hit_data  (hit_data)
  );

  // lowest invalid way wins, else round-robin
  always_comb begin
    victim = rr_q[set_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_vec[w])
        victim = WAY_W'(w);
  end

  // round-robin advances only on full-set fills
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        rr_q[s] <= '0;
    end else if (WAYS > 1 && fill_en &&
                 (&valid_vec)) begin
      rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
    end
  end

  // lookup / miss / fill sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_addr      <= '0;
      fill_inst     <= '0;
      bus.rd_rdy    <= 1'b0;
      bus.inst      <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
    end else begin
      bus.rd_rdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rd_en) begin
            req_addr <= bus.addr;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            bus.rd_rdy <= 1'b1;
            bus.inst   <=
              hit_data[word*INST_W +: INST_W];
            state      <= IDLE;
          end else begin
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= line_addr;
            state         <= MISS;
          end
        end
        MISS: begin
          if (bus.mem_rd_rdy) begin
            bus.mem_rd_en <= 1'b0;
            fill_inst     <=
              bus.mem_data[word*INST_W +: INST_W];
            state         <= FILL;
          end
        end
        FILL: begin
          bus.rd_rdy <= 1'b1;
          bus.inst   <= fill_inst;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // saturating hit/miss statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_cnt != '1)
        hit_cnt <= hit_cnt + 1'b1;
      if (!hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule
